tx_sequencer: RTL and testbench

TX_SEQUENCER -- requirements
Module: tx_sequencer

---
 rtl/tx_sequencer_if.sv | 28 ++
 rtl/tx_sequencer.sv | 122 ++++++++++++
 tb/tb_tx_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tx_sequencer_if.sv
// Sequencer-side bus: arbiter channel select, FIFO heads/pops, serializer handshake, packet counters.
interface tx_sequencer_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic [1:0]        rdy_cnl;
  logic [BYTE_W-1:0] f1_dout;
  logic [BYTE_W-1:0] f2_dout;
  logic              f1_rd;
  logic              f2_rd;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              next;
  logic [CNT_W-1:0]  cnt_ch1;
  logic [CNT_W-1:0]  cnt_ch2;
  logic [CNT_W-1:0]  cnt_empty;

  modport master (
    input  rdy_cnl, f1_dout, f2_dout, tx_ready,
    output f1_rd, f2_rd, tx_data, tx_valid, next, cnt_ch1, cnt_ch2, cnt_empty
  );

  modport slave (
    output rdy_cnl, f1_dout, f2_dout, tx_ready,
    input  f1_rd, f2_rd, tx_data, tx_valid, next, cnt_ch1, cnt_ch2, cnt_empty
  );
endinterface

// File: rtl/tx_sequencer.sv
// Packet sequencer: frames FIFO payload as header / payload / XOR checksum towards a serializer,
// then pulses next so the arbiter can publish a new channel.
module tx_sequencer #(
  parameter int unsigned PAYLOAD_LEN = 8,
  parameter logic [3:0]  SYNC        = 4'hA
) (
  input  logic           clk,
  input  logic           rst_n,
  tx_sequencer_if.master bus
);

  localparam int unsigned BYTE_W   = 8;
  localparam logic [7:0]  LAST_IDX = 8'(PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_HDR,
    ST_PLD,
    ST_CHK,
    ST_NEXT
  } state_t;

  state_t            state_q;
  logic [1:0]        settle_cnt_q;
  logic [1:0]        chan_q;
  logic [BYTE_W-1:0] byte_cnt_q;
  logic [BYTE_W-1:0] chk_q;
  logic [BYTE_W-1:0] tx_data_q;

  logic [1:0]        chan_c;
  logic [BYTE_W-1:0] pld_byte_c;
  logic              accept_c;
  logic              in_pld_c;

  // Code 11 is not a legal grant; fold it into an empty packet.
  assign chan_c   = (bus.rdy_cnl == 2'b11) ? 2'b00 : bus.rdy_cnl;
  assign accept_c = bus.tx_valid & bus.tx_ready;
  assign in_pld_c = (state_q == ST_PLD);

  always_comb begin
    pld_byte_c = '0;
    case (chan_q)
      2'b01:   pld_byte_c = bus.f1_dout;
      2'b10:   pld_byte_c = bus.f2_dout;
      default: pld_byte_c = '0;
    endcase
  end

  // Payload bytes come straight from the FWFT head so a pop and its byte share one cycle.
  assign bus.tx_data = in_pld_c ? pld_byte_c : tx_data_q;
  assign bus.f1_rd   = in_pld_c & accept_c & (chan_q == 2'b01);
  assign bus.f2_rd   = in_pld_c & accept_c & (chan_q == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SETTLE;
      settle_cnt_q  <= '0;
      chan_q        <= '0;
      byte_cnt_q    <= '0;
      chk_q         <= '0;
      tx_data_q     <= '0;
      bus.tx_valid  <= 1'b0;
      bus.next      <= 1'b0;
      bus.cnt_ch1   <= '0;
      bus.cnt_ch2   <= '0;
      bus.cnt_empty <= '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          chk_q      <= '0;
          byte_cnt_q <= '0;
          if (settle_cnt_q == 2'd1) begin
            settle_cnt_q <= '0;
            chan_q       <= chan_c;
            tx_data_q    <= {SYNC, 2'b00, chan_c};
            bus.tx_valid <= 1'b1;
            state_q      <= ST_HDR;
          end else begin
            settle_cnt_q <= settle_cnt_q + 2'd1;
          end
        end
        ST_HDR: begin
          if (accept_c) begin
            chk_q   <= chk_q ^ tx_data_q;
            state_q <= ST_PLD;
          end
        end
        ST_PLD: begin
          if (accept_c) begin
            chk_q <= chk_q ^ pld_byte_c;
            if (byte_cnt_q == LAST_IDX) begin
              byte_cnt_q <= '0;
              tx_data_q  <= chk_q ^ pld_byte_c;
              state_q    <= ST_CHK;
            end else begin
              byte_cnt_q <= byte_cnt_q + 8'd1;
            end
          end
        end
        ST_CHK: begin
          if (accept_c) begin
            bus.tx_valid <= 1'b0;
            bus.next     <= 1'b1;
            tx_data_q    <= '0;
            state_q      <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          bus.next <= 1'b0;
          case (chan_q)
            2'b01:   bus.cnt_ch1   <= bus.cnt_ch1 + 16'd1;
            2'b10:   bus.cnt_ch2   <= bus.cnt_ch2 + 16'd1;
            default: bus.cnt_empty <= bus.cnt_empty + 16'd1;
          endcase
          state_q <= ST_SETTLE;
        end
        default: state_q <= ST_SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_sequencer.sv
// Randomized bench for tx_sequencer: FIFO/serializer models plus a packet-level reference.
module tb_tx_sequencer;
  localparam int unsigned PLEN = 8;

  logic clk;
  logic rst_n;

  tx_sequencer_if bus ();

  tx_sequencer #(.PAYLOAD_LEN(PLEN), .SYNC(4'hA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  f1_q[$];
  logic [7:0]  f2_q[$];
  logic [15:0] exp_ch1, exp_ch2, exp_empty;
  logic [7:0]  last_hdr, last_chk;
  int          first_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refill();
    while (f1_q.size() < 32) f1_q.push_back(8'($urandom));
    while (f2_q.size() < 32) f2_q.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_next", bus.next, 0);
    check_eq("rst_f1_rd", bus.f1_rd, 0);
    check_eq("rst_f2_rd", bus.f2_rd, 0);
    check_eq("rst_cnt_ch1", bus.cnt_ch1, 0);
    check_eq("rst_cnt_ch2", bus.cnt_ch2, 0);
    check_eq("rst_cnt_empty", bus.cnt_empty, 0);
  endtask

  // mode: 0 = ready always, 1 = ready toggles 1/0, 2 = random ready. abort_at > 0 returns
  // right after that many bytes have been accepted.
  task automatic run_packet(input logic [1:0] code, input int mode, input int abort_at);
    logic [1:0] ch;
    logic [7:0] exp_b[$];
    logic [7:0] x, b, prev;
    int idx, rd1, rd2, cyc;
    bit done, stalled;
    ch = (code == 2'b11) ? 2'b00 : code;
    refill();
    bus.rdy_cnl = code;
    x = {4'hA, 2'b00, ch};
    exp_b.push_back(x);
    for (int i = 0; i < PLEN; i++) begin
      b = (ch == 2'b01) ? f1_q[i] : (ch == 2'b10) ? f2_q[i] : 8'h00;
      exp_b.push_back(b);
      x ^= b;
    end
    exp_b.push_back(x);
    idx = 0; rd1 = 0; rd2 = 0; cyc = 0; done = 0; stalled = 0; prev = '0;
    first_valid = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = cyc[0];
        default: bus.tx_ready = ($urandom % 3) != 0;
      endcase
      bus.f1_dout = f1_q[0];
      bus.f2_dout = f2_q[0];
      #1;
      if (bus.tx_valid && first_valid == 0) first_valid = cyc;
      if (stalled && bus.tx_valid) check_eq("stall_hold", bus.tx_data, prev);
      stalled = bus.tx_valid && !bus.tx_ready;
      prev = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        if (idx < exp_b.size()) check_eq($sformatf("byte%0d", idx), bus.tx_data, exp_b[idx]);
        else check_eq("extra_byte", idx, exp_b.size());
        if (idx == 0) begin
          last_hdr = bus.tx_data;
          bus.rdy_cnl = 2'($urandom);
        end
        last_chk = bus.tx_data;
        idx++;
      end
      if (bus.f1_rd) begin rd1++; void'(f1_q.pop_front()); end
      if (bus.f2_rd) begin rd2++; void'(f2_q.pop_front()); end
      if (abort_at > 0 && idx == abort_at) return;
      if (bus.next) done = 1;
    end
    check_eq("pkt_done", done, 1);
    check_eq("byte_count", idx, PLEN + 2);
    check_eq("f1_pops", rd1, (ch == 2'b01) ? PLEN : 0);
    check_eq("f2_pops", rd2, (ch == 2'b10) ? PLEN : 0);
    case (ch)
      2'b01:   exp_ch1++;
      2'b10:   exp_ch2++;
      default: exp_empty++;
    endcase
    @(negedge clk);
    #1;
    check_eq("next_one_cycle", bus.next, 0);
    check_eq("idle_valid", bus.tx_valid, 0);
    check_eq("cnt_ch1", bus.cnt_ch1, exp_ch1);
    check_eq("cnt_ch2", bus.cnt_ch2, exp_ch2);
    check_eq("cnt_empty", bus.cnt_empty, exp_empty);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rdy_cnl = 2'b01;
    bus.tx_ready = 1'b1;
    bus.f1_dout = '0;
    bus.f2_dout = '0;
    exp_ch1 = '0; exp_ch2 = '0; exp_empty = '0;
    for (int i = 1; i <= 8; i++) f1_q.push_back(8'(i));
    refill();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();

    // Channel 1 with known bytes 01..08
    @(negedge clk);
    rst_n = 1'b1;
    run_packet(2'b01, 0, 0);
    check_eq("first_sample_delay", first_valid, 2);
    check_eq("ch1_hdr", last_hdr, 8'hA1);
    check_eq("ch1_chk", last_chk, 8'hA9);

    run_packet(2'b00, 0, 0);
    check_eq("empty_hdr", last_hdr, 8'hA0);
    check_eq("empty_chk", last_chk, 8'hA0);

    run_packet(2'b10, 1, 0);
    check_eq("ch2_hdr", last_hdr, 8'hA2);

    // Reset in the middle of the payload
    run_packet(2'b01, 0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_ch1 = '0; exp_ch2 = '0; exp_empty = '0;
    repeat (2) @(negedge clk);
    bus.rdy_cnl = 2'b01;
    rst_n = 1'b1;
    run_packet(2'b01, 0, 0);
    check_eq("post_rst_delay", first_valid, 2);
    check_eq("post_rst_hdr", last_hdr, 8'hA1);

    run_packet(2'b11, 2, 0);
    check_eq("code11_hdr", last_hdr, 8'hA0);

    // Counter wrap
    force bus.cnt_ch1 = 16'hFFFF;
    #1;
    release bus.cnt_ch1;
    exp_ch1 = 16'hFFFF;
    check_eq("forced_cnt_ch1", bus.cnt_ch1, 16'hFFFF);
    run_packet(2'b01, 0, 0);
    check_eq("cnt_ch1_wrap", bus.cnt_ch1, 16'h0000);

    for (int k = 0; k < 20; k++) begin
      run_packet(2'($urandom_range(0, 3)), $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
